// File: rtl/inst_sram_resp.sv
// inst_sram_resp: fetch-port SRAM with 1-cycle reads, byte writes and stall-stable rdata.
// Define INST_SRAM_PRELOAD_EN to add the streaming preload port and its LOAD/RUN FSM.
module inst_sram_resp #(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        mem_ready,
    output logic [31:0] acc_cnt,
    output logic        oor_err
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] offset;
    logic        in_win;
    logic [ADDR_W-1:0] idx;
    logic        live;
    logic        live_in_reset;
    logic        wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        cpu_wr;

    assign offset = inst_sram_addr - BASE_ADDR;
    assign in_win = (offset >> (ADDR_W + 2)) == 32'd0;
    assign idx    = offset[ADDR_W+1:2];
    assign cpu_wr = resetn && live && inst_sram_en && (inst_sram_we != 4'd0) && in_win;

`ifdef INST_SRAM_PRELOAD_EN
    typedef enum logic {LOAD, RUN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] ld_idx;
    logic              ld_wr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= LOAD;
            ld_idx <= '0;
        end else if (state == LOAD && ld_valid) begin
            ld_idx <= ld_idx + 1'b1;
            if (ld_last || &ld_idx) state <= RUN;
        end
    end

    assign ld_ready      = state == LOAD;
    assign mem_ready     = state == RUN;
    assign live          = state == RUN;
    assign live_in_reset = 1'b0;
    assign ld_wr         = resetn && state == LOAD && ld_valid;
    assign wr_en         = ld_wr || cpu_wr;
    assign wr_idx        = ld_wr ? ld_idx : idx;
    assign wr_data       = ld_wr ? ld_data : inst_sram_wdata;
    assign wr_be         = ld_wr ? 4'hf : inst_sram_we;
`else
    logic unused_ld;
    assign unused_ld     = ^{ld_valid, ld_last, ld_data};
    assign ld_ready      = 1'b0;
    assign mem_ready     = 1'b1;
    assign live          = 1'b1;
    assign live_in_reset = 1'b1;
    assign wr_en         = cpu_wr;
    assign wr_idx        = idx;
    assign wr_data       = inst_sram_wdata;
    assign wr_be         = inst_sram_we;
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end

    // Reads see the pre-write word; the reset-cycle fetch is serviced when the port is live from reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_sram_rdata <= (live_in_reset && inst_sram_en && inst_sram_we == 4'd0 && in_win) ? mem[idx] : 32'd0;
            oor_err         <= 1'b0;
            acc_cnt         <= 32'd0;
        end else if (live && inst_sram_en) begin
            inst_sram_rdata <= in_win ? mem[idx] : 32'd0;
            oor_err         <= oor_err | ~in_win;
            if (inst_sram_we == 4'd0 && ~&acc_cnt) acc_cnt <= acc_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_inst_sram_resp.sv
// tb_inst_sram_resp: scoreboard bench for inst_sram_resp; follows INST_SRAM_PRELOAD_EN for the preload tests.
module tb_inst_sram_resp;
    localparam int          ADDR_W = 16;
    localparam logic [31:0] BASE   = 32'h1c000000;
    localparam int          DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0, resetn = 1'b0, en = 1'b0;
    logic [3:0]  we = 4'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, ld_data = 32'd0;
    logic        ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0] rdata, acc_cnt;
    logic        ld_ready, mem_ready, oor_err;

    inst_sram_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(en), .inst_sram_we(we), .inst_sram_addr(addr),
        .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .mem_ready(mem_ready), .acc_cnt(acc_cnt), .oor_err(oor_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [31:0] mm [int];
    logic [32:0] q [$];
    logic [32:0] last = 33'd0;
    logic [31:0] acc_m = 32'd0;
    logic        oor_m = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle: the model predicts rdata (bit 32 = known), queues it, then compares after the edge.
    task automatic cpu(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off, v;
        logic        in_w;
        int          i;
        logic [32:0] exp, got;
        off  = a - BASE;
        in_w = off < 32'(4 * DEPTH);
        i    = int'(off[ADDR_W+1:2]);
        exp  = last;
        if (e) begin
            exp = !in_w ? {1'b1, 32'd0} : mm.exists(i) ? {1'b1, mm[i]} : 33'd0;
            if (!in_w) oor_m = 1'b1;
            else if (w != 4'd0) begin
                v = mm.exists(i) ? mm[i] : 32'd0;
                for (int b = 0; b < 4; b++) if (w[b]) v[8*b +: 8] = d[8*b +: 8];
                mm[i] = v;
            end
            if (w == 4'd0 && acc_m != 32'hffffffff) acc_m = acc_m + 32'd1;
        end
        last = exp;
        q.push_back(exp);
        en = e; we = w; addr = a; wdata = d;
        tick;
        got = q.pop_front();
        if (got[32]) begin
            checks++;
            if (rdata !== got[31:0]) begin
                errors++;
                $display("FAIL rdata addr=%h got=%h exp=%h", a, rdata, got[31:0]);
            end
        end
        en = 1'b0; we = 4'd0;
    endtask

    task automatic test_setup;
        cpu(1'b1, 4'hf, BASE,       32'h02800c0c);
        cpu(1'b1, 4'hf, BASE + 4,   32'h13579bdf);
        cpu(1'b1, 4'hf, BASE + 8,   32'h11223344);
        cpu(1'b1, 4'hf, BASE + 12,  32'h00000000);
    endtask

`ifdef INST_SRAM_PRELOAD_EN
    task automatic test_preload;
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        checks += 3;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset ld_ready got=%b exp=1", ld_ready); end
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset mem_ready got=%b exp=0", mem_ready); end
        if (rdata !== 32'd0) begin errors++; $display("FAIL reset rdata got=%h exp=0", rdata); end
        en = 1'b1; addr = 32'd0;
        ld_valid = 1'b1; ld_data = 32'h1; tick;
        ld_valid = 1'b0; tick;
        ld_valid = 1'b1; ld_data = 32'h2; tick;
        checks++;
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL load mem_ready early got=%b exp=0", mem_ready); end
        ld_data = 32'h3; ld_last = 1'b1; tick;
        ld_valid = 1'b0; ld_last = 1'b0; en = 1'b0;
        checks += 5;
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL load mem_ready got=%b exp=1", mem_ready); end
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL load ld_ready got=%b exp=0", ld_ready); end
        if (rdata !== 32'd0) begin errors++; $display("FAIL load rdata got=%h exp=0", rdata); end
        if (acc_cnt !== 32'd0) begin errors++; $display("FAIL load acc_cnt got=%0d exp=0", acc_cnt); end
        if (oor_err !== 1'b0) begin errors++; $display("FAIL load oor_err got=%b exp=0", oor_err); end
        mm[0] = 32'h1; mm[1] = 32'h2; mm[2] = 32'h3;
        last = {1'b1, 32'd0};
        cpu(1'b1, 4'd0, BASE, 0);
        cpu(1'b1, 4'd0, BASE + 4, 0);
        cpu(1'b1, 4'd0, BASE + 8, 0);
    endtask

    task automatic test_reload;
        resetn = 1'b0; tick; resetn = 1'b1;
        ld_valid = 1'b1; ld_data = 32'ha; tick;
        ld_data = 32'hb; tick;
        resetn = 1'b0; ld_valid = 1'b0; tick;
        resetn = 1'b1;
        ld_valid = 1'b1; ld_data = 32'h9; ld_last = 1'b1; tick;
        ld_valid = 1'b0; ld_last = 1'b0;
        checks++;
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL reload mem_ready got=%b exp=1", mem_ready); end
        mm[0] = 32'h9; mm[1] = 32'hb;
        acc_m = 32'd0; oor_m = 1'b0; last = {1'b1, 32'd0};
        cpu(1'b1, 4'd0, BASE, 0);
        cpu(1'b1, 4'd0, BASE + 4, 0);
        cpu(1'b1, 4'd0, BASE + 8, 0);
    endtask
`else
    task automatic test_reset;
        resetn = 1'b0; en = 1'b1; we = 4'd0; addr = BASE;
        tick;
        resetn = 1'b1; en = 1'b0;
        acc_m = 32'd0; oor_m = 1'b0; last = {1'b1, 32'h02800c0c};
        checks += 5;
        if (rdata !== 32'h02800c0c) begin errors++; $display("FAIL reset_read got=%h exp=02800c0c", rdata); end
        if (oor_err !== 1'b0) begin errors++; $display("FAIL reset oor_err got=%b exp=0", oor_err); end
        if (acc_cnt !== 32'd0) begin errors++; $display("FAIL reset acc_cnt got=%0d exp=0", acc_cnt); end
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset ld_ready got=%b exp=0", ld_ready); end
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset mem_ready got=%b exp=1", mem_ready); end
    endtask
`endif

    task automatic test_hold;
        cpu(1'b1, 4'd0, BASE + 4, 0);
        repeat (5) cpu(1'b0, 4'd0, BASE + 8, 0);
        checks++;
        if (acc_cnt !== acc_m) begin errors++; $display("FAIL hold acc_cnt got=%0d exp=%0d", acc_cnt, acc_m); end
    endtask

    task automatic test_byte_write;
        cpu(1'b1, 4'b0101, BASE + 8, 32'haabbccdd);
        cpu(1'b1, 4'd0, BASE + 8, 0);
        checks++;
        if (rdata !== 32'h11bb33dd) begin errors++; $display("FAIL byte_merge got=%h exp=11bb33dd", rdata); end
    endtask

    task automatic test_write_then_read;
        cpu(1'b1, 4'hf, BASE + 12, 32'hcafef00d);
        cpu(1'b1, 4'd0, BASE + 12, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) cpu(1'b1, 4'd0, BASE + 32'(4 * (i % 4)), 0);
        checks++;
        if (acc_cnt !== acc_m) begin errors++; $display("FAIL b2b acc_cnt got=%0d exp=%0d", acc_cnt, acc_m); end
    endtask

    task automatic test_oor;
        cpu(1'b1, 4'd0, 32'h1bfffffc, 0);
        checks++;
        if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_read flag got=%b exp=1", oor_err); end
        cpu(1'b1, 4'hf, BASE + 32'(4 * DEPTH), 32'hdeadbeef);
        repeat (3) cpu(1'b0, 4'd0, 0, 0);
        cpu(1'b1, 4'd0, BASE, 0);
        checks += 2;
        if (oor_err !== oor_m) begin errors++; $display("FAIL oor_sticky got=%b exp=%b", oor_err, oor_m); end
        if (acc_cnt !== acc_m) begin errors++; $display("FAIL oor acc_cnt got=%0d exp=%0d", acc_cnt, acc_m); end
    endtask

    initial begin
`ifdef INST_SRAM_PRELOAD_EN
        test_preload;
        test_reload;
        test_setup;
`else
        resetn = 1'b0; tick; resetn = 1'b1;
        test_setup;
        test_reset;
`endif
        test_hold;
        test_byte_write;
        test_write_then_read;
        test_back_to_back;
        test_oor;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_sram_resp.md
# inst_sram_resp

Instruction-side synchronous SRAM responder for the pipeline's fetch port. It services the fetch stage's `inst_sram_*` requests with fixed one-cycle read latency and byte-granular writes. It holds read data stable while the fetch stage stalls, and flags accesses outside its window. An optional streaming preload port fills the array from a loader after reset, before the CPU is released.

## Interface
Parameters:
- `ADDR_W`, 16: word-index width; depth = 2^ADDR_W words.
- `BASE_ADDR`, 32'h1c000000: byte address of word 0; window = BASE_ADDR .. BASE_ADDR + 4·2^ADDR_W − 1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset: synchronous, active-low.
- `inst_sram_en`  in  1  access request this cycle.
- `inst_sram_we`  in  4  byte write enables; 0 = read.
- `inst_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `inst_sram_wdata`  in  32  write data.
- `inst_sram_rdata`  out  32  read data, registered.
- `ld_valid`  in  1  preload word valid.
- `ld_ready`  out  1  preload word accepted when high with `ld_valid`.
- `ld_data`  in  32  preload word.
- `ld_last`  in  1  marks final preload word.
- `mem_ready`  out  1  array loaded; top holds CPU reset while low.
- `acc_cnt`  out  32  CPU read-access counter, saturating.
- `oor_err`  out  1  sticky out-of-window access flag.

## Operation
- Offset = addr − BASE_ADDR (32-bit modular); in-window iff offset < 4·2^ADDR_W; index = offset[ADDR_W+1:2].
- Read (en=1, we=0, in-window): rdata ← mem[index] at next edge. Out-of-window read: rdata ← 0, oor_err ← 1.
- Write (en=1, we≠0, in-window): each set we[i] writes byte i of wdata. rdata ← old mem[index] (read-before-write). Out-of-window write is dropped; oor_err ← 1.
- en=0: rdata holds its last value indefinitely. The fetch stage depends on this during stalls.
- Array contents are never reset.
- acc_cnt: +1 per accepted CPU read, regardless of window; saturates at 32'hffffffff.
- Preload FSM (macro-enabled only), states LOAD and RUN:
  - LOAD: ld_ready=1, mem_ready=0. On ld_valid, mem[ld_idx] ← ld_data and ld_idx++.
  - LOAD→RUN: on accepted word with ld_last=1, or at ld_idx = 2^ADDR_W−1 (no wrap).
  - RUN: ld_ready=0, mem_ready=1; stays until reset.
- CPU port in LOAD: requests ignored; rdata holds; no oor_err or acc_cnt update.

## Timing
- Reset values:
  - rdata = 0, unless a read request is present in the reset cycle.
  - oor_err = 0; acc_cnt = 0.
  - FSM = LOAD with ld_idx = 0 when the macro is defined; RUN otherwise.
  - ld_ready = 1 / mem_ready = 0 after reset when the macro is defined; ld_ready = 0 / mem_ready = 1 otherwise.
- Read during reset: the fetch stage issues its first fetch (0x1c000000) with resetn low. When the macro is undefined, the responder must service that read, so rdata valid the cycle after. Counters and flags still reset.
- Read latency: exactly 1 cycle, en edge → rdata. Back-to-back reads every cycle, no bubbles.
- Same-address write then read on the next cycle returns the new data.
- Preload: one word per cycle max; ld_ready combinational from state only. Final-word acceptance → mem_ready high on the next cycle.
- Reset mid-preload: FSM returns to LOAD, ld_idx = 0; partially written words persist.

## Configuration
- `INST_SRAM_PRELOAD_EN` defined: preload port and FSM present as above.
- Undefined: FSM absent, ld_ready tied 0, ld_* ignored, mem_ready tied 1, CPU port live from the reset cycle.

## Test plan
- Reset with en=1, addr=0x1c000000, mem[0]=0x02800c0c (macro off) → rdata=0x02800c0c the cycle after; oor_err=0, acc_cnt=0 after reset.
- Read 0x1c000004, then hold en=0 for 5 cycles → rdata stays mem[1] all 5 cycles; acc_cnt=1.
- Write we=4'b0101, wdata=0xaabbccdd to 0x1c000008 over 0x11223344 → rdata that cycle = 0x11223344; re-read → 0x11bb33dd.
- Read 0x1bfffffc and write 0x1c000000+4·2^ADDR_W → rdata=0, oor_err=1 stays set, memory unchanged.
- Macro on: stream 3 words 0x1,0x2,0x3 (last on 3rd) with a 1-cycle ld_valid gap → mem_ready rises 1 cycle after 3rd; CPU reads at 0x1c000000/4/8 return 1/2/3; CPU en during LOAD ignored.
- Macro on: reset after 2 loaded words, reload 1 word 0x9 with ld_last → mem[0]=0x9, mem[1] retains old value, mem_ready=1.
